// File: rtl/multi_bank_mem_bist.sv
// BIST initiator: writes SEED^addr to all locations, reads back and compares; reports pass, error count, first fail.
// Optional inverted second pass (~pattern) enabled by defining MULTI_BANK_BIST_INV_PASS_EN.
module multi_bank_mem_bist #(
  parameter int              ADDR_W     = 5,
  parameter int              DATA_W     = 8,
  parameter logic [DATA_W-1:0] SEED     = 8'hA5,
  parameter int              ACC_CYCLES = 2,
  parameter int              RD_LAT     = 3
) (
  input  logic              clk_pi,
  input  logic              rst_pi,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [5:0]        err_cnt_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CYC_W = $clog2(RD_LAT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
`ifdef MULTI_BANK_BIST_INV_PASS_EN
    S_INV_WR,
    S_INV_RD,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              start_acc, rd_cmp, acc_last;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [5:0]        err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              acc_d;

  function automatic logic f_wr(input state_t s);
`ifdef MULTI_BANK_BIST_INV_PASS_EN
    return (s == S_WR) || (s == S_INV_WR);
`else
    return (s == S_WR);
`endif
  endfunction

  function automatic logic f_rd(input state_t s);
`ifdef MULTI_BANK_BIST_INV_PASS_EN
    return (s == S_RD) || (s == S_INV_RD);
`else
    return (s == S_RD);
`endif
  endfunction

  function automatic logic f_inv(input state_t s);
`ifdef MULTI_BANK_BIST_INV_PASS_EN
    return (s == S_INV_WR) || (s == S_INV_RD);
`else
    return (s == S_DONE) && 1'b0;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] f_pat(input logic [ADDR_W-1:0] a, input logic inv);
    return SEED ^ DATA_W'(a) ^ {DATA_W{inv}};
  endfunction

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cyc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // cyc_q counts edges within one access; the access ends on its last edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    start_acc = 1'b0;
    rd_cmp    = 1'b0;
    acc_last  = f_wr(state_q) ? (cyc_q == CYC_W'(ACC_CYCLES - 1))
                              : (cyc_q == CYC_W'(RD_LAT - 1));
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = S_WR;
          cnt_d     = '0;
          cyc_d     = '0;
        end
      end
      default: begin
        if (acc_last) begin
          cyc_d  = '0;
          cnt_d  = cnt_q + 1'b1;
          rd_cmp = f_rd(state_q);
          if (&cnt_q) begin
            case (state_q)
              S_WR:     state_d = S_RD;
`ifdef MULTI_BANK_BIST_INV_PASS_EN
              S_RD:     state_d = S_INV_WR;
              S_INV_WR: state_d = S_INV_RD;
              S_INV_RD: state_d = S_DONE;
`else
              S_RD:     state_d = S_DONE;
`endif
              default:  state_d = S_IDLE;
            endcase
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    acc_d       = f_wr(state_d) || f_rd(state_d);
    busy_d      = acc_d;
    done_d      = (state_d == S_DONE);
    mem_en_d    = acc_d;
    mem_we_d    = f_wr(state_d);
    mem_addr_d  = acc_d ? cnt_d : '0;
    mem_wdata_d = f_wr(state_d) ? f_pat(cnt_d, f_inv(state_d)) : '0;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    if (start_acc) begin
      err_cnt_d   = '0;
      fail_addr_d = '0;
    end else if (rd_cmp && (mem_rdata_i != f_pat(cnt_q, f_inv(state_q)))) begin
      if (err_cnt_q != 6'd63) err_cnt_d = err_cnt_q + 6'd1;
      if (err_cnt_q == 6'd0)  fail_addr_d = cnt_q;
    end
    pass_d = done_d && (err_cnt_d == 6'd0);
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_cnt_o   = err_cnt_q;
  assign fail_addr_o = fail_addr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_multi_bank_mem_bist.sv
// Bench for multi_bank_mem_bist: memory model with per-address read fault masks, results checked against a pass-level model.
module tb_multi_bank_mem_bist;

  localparam logic [7:0] SEED = 8'hA5;
  localparam int ACC = 2;
  localparam int RDL = 3;
`ifdef MULTI_BANK_BIST_INV_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       busy_o, done_o, pass_o, mem_en_o, mem_we_o;
  logic [5:0] err_cnt_o;
  logic [4:0] fail_addr_o, mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic [7:0] mem_rdata = 8'h00;

  logic [7:0] mem [32];
  logic [7:0] and_m [32];
  logic [7:0] or_m [32];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_bank_mem_bist dut (
    .clk_pi(clk), .rst_pi(rst), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_cnt_o(err_cnt_o), .fail_addr_o(fail_addr_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata)
  );

  // Memory with registered read path; faults applied on the read side only.
  always @(posedge clk) begin
    if (mem_en_o && mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
    if (mem_en_o && !mem_we_o)
      mem_rdata <= (mem[mem_addr_o] & and_m[mem_addr_o]) | or_m[mem_addr_o];
    else
      mem_rdata <= 8'h00;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 32; a++) begin
      and_m[a] = 8'hFF;
      or_m[a]  = 8'h00;
    end
  endtask

  task automatic model(output int e_cnt, output int e_fail);
    logic [7:0] e, r;
    e_cnt = 0;
    e_fail = 0;
    for (int p = 0; p < PASSES; p++)
      for (int a = 0; a < 32; a++) begin
        e = SEED ^ 8'(a);
        if (p == 1) e = ~e;
        r = (e & and_m[a]) | or_m[a];
        if (r != e) begin
          if (e_cnt == 0) e_fail = a;
          if (e_cnt < 63) e_cnt++;
        end
      end
  endtask

  task automatic run_bist(input string tag, input int rst_at, input bit poke);
    int n;
    int e_cnt, e_fail;
    model(e_cnt, e_fail);
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    chk_eq({tag, "_first_acc"}, {busy_o, done_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o},
           {1'b1, 1'b0, 1'b1, 1'b1, 5'd0, SEED});
    n = 0;
    while (!done_o && n < 2000) begin
      start_i = poke && (n == 10 || n == 100);
      if (rst_at != 0 && n == rst_at) begin
        start_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_eq({tag, "_rst_outs"},
               {busy_o, done_o, pass_o, err_cnt_o, fail_addr_o, mem_addr_o, mem_wdata_o, mem_en_o, mem_we_o},
               32'd0);
        repeat (3) @(negedge clk);
        chk_eq({tag, "_rst_idle"}, {busy_o, done_o, mem_en_o}, 3'b000);
        return;
      end
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    chk_eq({tag, "_done_time"}, n, PASSES * 32 * (ACC + RDL));
    chk_eq({tag, "_done"}, done_o, 1'b1);
    chk_eq({tag, "_pass"}, pass_o, (e_cnt == 0));
    chk_eq({tag, "_err_cnt"}, err_cnt_o, e_cnt);
    chk_eq({tag, "_fail_addr"}, fail_addr_o, e_fail);
    chk_eq({tag, "_idle_bus"}, {busy_o, mem_en_o}, 2'b00);
    repeat (2) @(negedge clk);
    chk_eq({tag, "_done_held"}, {done_o, err_cnt_o}, {1'b1, 6'(e_cnt)});
  endtask

  initial begin
    int k, a;
    clear_faults();
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7);
    repeat (3) @(negedge clk);
    chk_eq("reset_state",
           {busy_o, done_o, pass_o, err_cnt_o, fail_addr_o, mem_addr_o, mem_wdata_o, mem_en_o, mem_we_o},
           32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_bist("t1_clean", 0, 1'b0);

    clear_faults(); and_m[13] = 8'h00;
    run_bist("t2_loc13", 0, 1'b0);

    clear_faults(); and_m[3] = 8'h00; and_m[20] = 8'h00; and_m[31] = 8'h00;
    run_bist("t3_multi", 0, 1'b0);

    clear_faults();
    run_bist("t4_poke", 0, 1'b1);

    run_bist("t5_reset", 50, 1'b0);
    run_bist("t5_after", 0, 1'b0);

    clear_faults(); and_m[5] = 8'hFE;
    run_bist("t6_stuck0", 0, 1'b0);

    clear_faults();
    for (int i = 0; i < 32; i++) or_m[i] = 8'hFF;
    run_bist("sat_all", 0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      clear_faults();
      k = $urandom_range(0, 5);
      for (int j = 0; j < k; j++) begin
        a = $urandom_range(0, 31);
        and_m[a] = 8'($urandom);
        or_m[a]  = 8'($urandom);
      end
      run_bist($sformatf("rnd%0d", r), 0, r[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
